ft2232h_fifo_arbiter: RTL and testbench

//  Owns the FT2232H synchronous-FIFO pin interface and time-shares the single bidirectional
//  8-bit bus between the host->FPGA read path (RXF#/RD#/OE#) and the FPGA->host write path
//  (TXE#/WR#). Sits between the pad tristate buffer and the user RX/TX byte streams.

---
 rtl/ft2232h_fifo_arbiter.sv | 130 +++++++++++++
 tb/tb_ft2232h_fifo_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2232h_fifo_arbiter.sv
// FT2232H synchronous-FIFO pin controller: round-robin RX/TX bus sharing
// with a per-grant burst cap and OE/RD and RD/WR bus turnaround cycles.
module ft2232h_fifo_arbiter #(
    parameter int MAX_BURST = 512,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rxf_n,
    input  logic       txe_n,
    input  logic [7:0] data_in,
    output logic       rd_n,
    output logic       oe_n,
    output logic       wr_n,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       rx_afull,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_OE,
        S_RX_RD,
        S_RX_END,
        S_TX_WR
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic             last_tx_q, last_tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_req, tx_req;

    assign rx_req = ~rxf_n & ~rx_afull;
    assign tx_req = ~txe_n & tx_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            last_tx_q  <= 1'b1;
            cnt_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_tx_q  <= last_tx_d;
            cnt_q      <= cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_tx_d  = last_tx_q;
        cnt_d      = cnt_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rd_n       = 1'b1;
        oe_n       = 1'b1;
        wr_n       = 1'b1;
        data_oe    = 1'b0;
        data_out   = 8'h00;
        tx_ready   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie the side that did not hold the last grant wins
                if (enable) begin
                    if (rx_req && (!tx_req || last_tx_q)) begin
                        state_d   = S_RX_OE;
                        last_tx_d = 1'b0;
                    end else if (tx_req) begin
                        state_d   = S_TX_WR;
                        last_tx_d = 1'b1;
                    end
                end
            end
            S_RX_OE: begin
                oe_n    = 1'b0;
                state_d = S_RX_RD;
            end
            S_RX_RD: begin
                oe_n = 1'b0;
                rd_n = ~rx_req;
                if (rx_req) begin
                    rx_data_d  = data_in;
                    rx_valid_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
                if (!rx_req || !enable || cnt_q == LAST) begin
                    state_d = S_RX_END;
                end
            end
            S_RX_END: begin
                state_d = S_IDLE;
            end
            S_TX_WR: begin
                data_oe  = 1'b1;
                data_out = tx_data;
                wr_n     = ~tx_req;
                tx_ready = tx_req;
                if (tx_req) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!tx_req || !enable || cnt_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft2232h_fifo_arbiter.sv
// Bench for ft2232h_fifo_arbiter: directed scenarios plus a randomized run
// scored against host/user byte queues and bus-protocol rules.
module tb_ft2232h_fifo_arbiter;
    localparam int MB = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b0;
    logic       rxf_n    = 1'b1;
    logic       txe_n    = 1'b1;
    logic       rx_afull = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic [7:0] tx_data  = 8'h00;
    logic       rd_n, oe_n, wr_n, data_oe, rx_valid, tx_ready, busy;
    logic [7:0] data_out, rx_data;

    int total  = 0;
    int passed = 0;

    ft2232h_fifo_arbiter #(.MAX_BURST(MB), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rxf_n(rxf_n), .txe_n(txe_n), .data_in(data_in),
        .rd_n(rd_n), .oe_n(oe_n), .wr_n(wr_n),
        .data_out(data_out), .data_oe(data_oe),
        .rx_afull(rx_afull), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; rxf_n = 1'b1; txe_n = 1'b1; rx_afull = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; data_in = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b0;
        #1;
        total++;
        if ({rd_n, wr_n, oe_n, data_oe, busy, rx_valid, tx_ready} !== 7'b1110000)
            $display("FAIL reset_strobes: got %b want 1110000",
                     {rd_n, wr_n, oe_n, data_oe, busy, rx_valid, tx_ready});
        else passed++;
        total++;
        if (data_out !== 8'h00 || rx_data !== 8'h00)
            $display("FAIL reset_data: got %h/%h want 00/00", data_out, rx_data);
        else passed++;
        tick();
        reset = 1'b1; enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; txe_n = 1'b0;
        tick();
        total++;
        if ({wr_n, data_oe, busy} !== 3'b011)
            $display("FAIL tx_grant: got %b want 011", {wr_n, data_oe, busy});
        else passed++;
        tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({rd_n, wr_n, oe_n, data_oe, busy, tx_ready} !== 6'b111000)
            $display("FAIL reset_mid_tx: got %b want 111000",
                     {rd_n, wr_n, oe_n, data_oe, busy, tx_ready});
        else passed++;
        idle_inputs();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_rx_burst();
        int   idx = 0, nval = 0, after = -1;
        logic prev_oe = 1'b1, xfer;
        logic [7:0] xb;
        enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rxf_n   = (idx >= 5);
            data_in = (idx < 5) ? 8'(16 + idx) : 8'h00;
            if (rxf_n && after < 0) after = 0;
            #1;
            if (oe_n == 1'b0 && prev_oe == 1'b1) begin
                total++;
                if (rd_n !== 1'b1) $display("FAIL rx_oe_lead: rd_n got %b want 1", rd_n);
                else passed++;
            end
            if (rd_n == 1'b0) begin
                total++;
                if (prev_oe !== 1'b0) $display("FAIL rx_rd_early: prev oe_n got %b want 0", prev_oe);
                else passed++;
            end
            if (after == 0) begin
                total++;
                if ({rd_n, oe_n} !== 2'b10) $display("FAIL rx_release: got %b want 10", {rd_n, oe_n});
                else passed++;
            end else if (after == 1) begin
                total++;
                if ({oe_n, busy} !== 2'b11) $display("FAIL rx_end: got %b want 11", {oe_n, busy});
                else passed++;
            end else if (after == 2) begin
                total++;
                if (busy !== 1'b0) $display("FAIL rx_idle: busy got %b want 0", busy);
                else passed++;
            end
            xfer = (rd_n == 1'b0 && rxf_n == 1'b0);
            xb = 8'(16 + idx);
            prev_oe = oe_n;
            tick();
            if (after >= 0) after++;
            if (xfer) idx++;
            total++;
            if (rx_valid !== xfer || (xfer && rx_data !== xb))
                $display("FAIL rx_strobe: got %b/%h want %b/%h", rx_valid, rx_data, xfer, xb);
            else passed++;
            if (rx_valid) nval++;
        end
        total++;
        if (nval != 5) $display("FAIL rx_count: got %0d want 5", nval);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_tx_burst();
        int   sent = 0, nwr = 0;
        logic dropped = 1'b0, drop_now, xfer;
        enable = 1'b1; rxf_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tx_valid = (sent < 4);
            tx_data  = 8'(160 + sent);
            drop_now = (!dropped && sent == 2);
            txe_n    = drop_now;
            if (drop_now) dropped = 1'b1;
            #1;
            total++;
            if (tx_ready !== ~wr_n) $display("FAIL tx_ready_wr: got %b/%b want opposite", tx_ready, wr_n);
            else passed++;
            if (drop_now) begin
                total++;
                if ({wr_n, tx_ready, data_oe} !== 3'b101 || data_out !== 8'hA2)
                    $display("FAIL tx_txe_release: got %b/%h want 101/a2",
                             {wr_n, tx_ready, data_oe}, data_out);
                else passed++;
            end
            if (wr_n == 1'b0) begin
                nwr++;
                total++;
                if (data_out !== 8'(160 + sent) || data_oe !== 1'b1)
                    $display("FAIL tx_data: got %h/%b want %h/1", data_out, data_oe, 8'(160 + sent));
                else passed++;
            end
            if (data_oe) begin
                total++;
                if ({oe_n, rd_n} !== 2'b11) $display("FAIL tx_bus_dir: got %b want 11", {oe_n, rd_n});
                else passed++;
            end
            xfer = tx_valid && tx_ready;
            tick();
            if (xfer) sent++;
        end
        total++;
        if (nwr != 4 || sent != 4 || busy !== 1'b0)
            $display("FAIL tx_count: got %0d/%0d/%b want 4/4/0", nwr, sent, busy);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_contention();
        int   run = 0, nruns = 0, last_c = -100;
        logic first = 1'b1, last_side = 1'b0, rx_x, tx_x;
        logic [7:0] xb;
        do_reset();
        enable = 1'b1; rxf_n = 1'b0; txe_n = 1'b0; tx_valid = 1'b1;
        tx_data = 8'($urandom); data_in = 8'($urandom);
        for (int c = 0; c < 60; c++) begin
            #1;
            total++;
            if (oe_n == 1'b0 && data_oe == 1'b1) $display("FAIL bus_contention: oe_n 0 with data_oe 1");
            else passed++;
            rx_x = (rd_n == 1'b0 && rxf_n == 1'b0);
            tx_x = (tx_valid && tx_ready);
            if (rx_x || tx_x) begin
                if (first) begin
                    total++;
                    if (tx_x) $display("FAIL first_grant: got TX want RX");
                    else passed++;
                    first = 1'b0;
                    run = 1;
                end else if (tx_x == last_side) begin
                    total++;
                    if (c != last_c + 1 || run >= MB)
                        $display("FAIL burst_run: gap %0d run %0d want 1/<%0d", c - last_c, run, MB);
                    else passed++;
                    run++;
                end else begin
                    total++;
                    if (run != MB) $display("FAIL burst_len: got %0d want %0d", run, MB);
                    else passed++;
                    total++;
                    if (c - last_c != 3) $display("FAIL turnaround: got %0d want 3", c - last_c);
                    else passed++;
                    run = 1;
                    nruns++;
                end
                last_side = tx_x;
                last_c = c;
            end
            xb = data_in;
            tick();
            total++;
            if (rx_valid !== rx_x || (rx_x && rx_data !== xb))
                $display("FAIL cont_rx: got %b/%h want %b/%h", rx_valid, rx_data, rx_x, xb);
            else passed++;
            if (tx_x) tx_data = 8'($urandom);
            data_in = 8'($urandom);
        end
        total++;
        if (nruns < 6) $display("FAIL grant_switches: got %0d want >=6", nruns);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int   nx = 0, nval = 0;
        logic rx_x;
        tick(); tick(); tick();
        enable = 1'b1; rxf_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            data_in = 8'($urandom);
            #1;
            if (rx_afull) begin
                total++;
                if (rd_n !== 1'b1) $display("FAIL afull_rd: got %b want 1", rd_n);
                else passed++;
            end
            rx_x = (rd_n == 1'b0 && rxf_n == 1'b0);
            tick();
            total++;
            if (rx_valid !== rx_x) $display("FAIL afull_strobe: got %b want %b", rx_valid, rx_x);
            else passed++;
            if (rx_valid) nval++;
            if (rx_x) nx++;
            if (nx == 3) rx_afull = 1'b1;
        end
        total++;
        if (nval != 3 || busy !== 1'b0 || oe_n !== 1'b1)
            $display("FAIL afull_total: got %0d/%b/%b want 3/0/1", nval, busy, oe_n);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_enable();
        logic [7:0] xb;
        do_reset();
        enable = 1'b0; rxf_n = 1'b0; txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h33;
        data_in = 8'h6C;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if ({rd_n, wr_n, oe_n, busy, tx_ready, data_oe} !== 6'b111000)
                $display("FAIL en_hold: got %b want 111000",
                         {rd_n, wr_n, oe_n, busy, tx_ready, data_oe});
            else passed++;
            tick();
        end
        enable = 1'b1;
        tick();
        total++;
        if ({oe_n, rd_n, wr_n, data_oe, busy} !== 5'b01101)
            $display("FAIL en_rx_first: got %b want 01101", {oe_n, rd_n, wr_n, data_oe, busy});
        else passed++;
        tick();
        enable = 1'b0;
        xb = data_in;
        #1;
        total++;
        if ({oe_n, rd_n} !== 2'b00) $display("FAIL en_last_byte: got %b want 00", {oe_n, rd_n});
        else passed++;
        tick();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== xb || {oe_n, busy} !== 2'b11)
            $display("FAIL en_end: got %b/%h/%b want 1/%h/11", rx_valid, rx_data, {oe_n, busy}, xb);
        else passed++;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || rx_valid !== 1'b0)
            $display("FAIL en_stop: got %b/%b want 0/0", busy, rx_valid);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] host_q[$];
        logic [7:0] xb;
        int   rx_run = 0, tx_run = 0, nrx = 0, ntx = 0;
        logic prev_oe = 1'b1, rx_x, tx_x;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 15) != 0);
            if (host_q.size() < 4 && $urandom_range(0, 1) != 0) host_q.push_back(8'($urandom));
            rxf_n    = (host_q.size() == 0) || ($urandom_range(0, 3) == 0);
            data_in  = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
            rx_afull = ($urandom_range(0, 4) == 0);
            txe_n    = ($urandom_range(0, 3) == 0);
            if (!tx_valid) begin
                tx_valid = ($urandom_range(0, 1) != 0);
                tx_data  = 8'($urandom);
            end
            #1;
            total++;
            if ((oe_n == 1'b0 && data_oe == 1'b1) || tx_ready !== ~wr_n)
                $display("FAIL rnd_bus: oe_n %b data_oe %b tx_ready %b wr_n %b", oe_n, data_oe, tx_ready, wr_n);
            else passed++;
            if (wr_n == 1'b0) begin
                total++;
                if (tx_valid !== 1'b1 || txe_n !== 1'b0 || data_out !== tx_data)
                    $display("FAIL rnd_wr: got %b/%b/%h want 1/0/%h", tx_valid, txe_n, data_out, tx_data);
                else passed++;
            end
            if (rd_n == 1'b0) begin
                total++;
                if (rxf_n !== 1'b0 || rx_afull !== 1'b0 || prev_oe !== 1'b0)
                    $display("FAIL rnd_rd: got %b/%b/%b want 0/0/0", rxf_n, rx_afull, prev_oe);
                else passed++;
            end
            rx_x = (rd_n == 1'b0 && rxf_n == 1'b0);
            tx_x = (tx_valid && tx_ready);
            rx_run = rx_x ? rx_run + 1 : 0;
            tx_run = tx_x ? tx_run + 1 : 0;
            if (rx_x || tx_x) begin
                total++;
                if (rx_run > MB || tx_run > MB || (rx_x && tx_x))
                    $display("FAIL rnd_burst: got %0d/%0d want <=%0d", rx_run, tx_run, MB);
                else passed++;
            end
            prev_oe = oe_n;
            xb = 8'h00;
            if (rx_x) xb = host_q.pop_front();
            tick();
            total++;
            if (rx_valid !== rx_x || (rx_x && rx_data !== xb))
                $display("FAIL rnd_rx: got %b/%h want %b/%h", rx_valid, rx_data, rx_x, xb);
            else passed++;
            if (rx_x) nrx++;
            if (tx_x) begin
                ntx++;
                tx_valid = 1'b0;
            end
        end
        total++;
        if (nrx < 50 || ntx < 50) $display("FAIL rnd_traffic: got %0d/%0d want >=50", nrx, ntx);
        else passed++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rx_burst();
        test_tx_burst();
        test_contention();
        test_backpressure();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
